// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter with grant/transaction ownership tracking.
// Define ARBITER_WATCHDOG_EN to enable the grant and bus-tenure watchdogs.
module bus_arbiter_rr #(
    parameter int NR_MASTERS    = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NR_MASTERS-1:0] request,
    input  logic                  begin_transaction_in,
    input  logic                  end_transaction_in,
    input  logic                  error_in,
    output logic [NR_MASTERS-1:0] granted,
    output logic [2:0]            bus_owner,
    output logic                  owner_valid,
    output logic                  end_transaction_out,
    output logic                  error_out
);

    if (NR_MASTERS < 2 || NR_MASTERS > 8) begin : g_bad_nr
        $error("NR_MASTERS out of range");
    end
    if (GRANT_TIMEOUT < 1 || GRANT_TIMEOUT > 65535) begin : g_bad_gt
        $error("GRANT_TIMEOUT out of range");
    end
    if (BUS_TIMEOUT < 1 || BUS_TIMEOUT > 65535) begin : g_bad_bt
        $error("BUS_TIMEOUT out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        BUSY,
`ifdef ARBITER_WATCHDOG_EN
        TIMEOUT,
`endif
        RELEASE
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              last_q, last_d;
    logic [2:0]              owner_q, owner_d;
    logic [NR_MASTERS-1:0]   granted_q, granted_d;
    logic                    valid_q;
    logic [2:0]              sel;

    // Lowest requester above last owner wins; otherwise wrap to the lowest.
    always_comb begin
        sel = '0;
        for (int j = NR_MASTERS - 1; j >= 0; j--) begin
            if (request[j] && j <= int'(last_q)) sel = 3'(j);
        end
        for (int j = NR_MASTERS - 1; j >= 0; j--) begin
            if (request[j] && j > int'(last_q)) sel = 3'(j);
        end
    end

`ifdef ARBITER_WATCHDOG_EN
    logic [15:0] cnt_q, cnt_d;
    logic        eot_q, err_q;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        granted_d = '0;
`ifdef ARBITER_WATCHDOG_EN
        cnt_d     = cnt_q + 16'd1;
`endif
        unique case (state_q)
            IDLE: begin
                if (|request) begin
                    state_d   = GRANT;
                    last_d    = sel;
                    owner_d   = sel;
                    granted_d = NR_MASTERS'(1) << sel;
`ifdef ARBITER_WATCHDOG_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                if (begin_transaction_in) begin
                    state_d = end_transaction_in ? RELEASE : BUSY;
`ifdef ARBITER_WATCHDOG_EN
                    cnt_d   = '0;
                end else if (cnt_q == 16'(GRANT_TIMEOUT - 1)) begin
                    state_d = RELEASE;
`endif
                end
            end
            BUSY: begin
                if (error_in || end_transaction_in) begin
                    state_d = RELEASE;
`ifdef ARBITER_WATCHDOG_EN
                end else if (cnt_q == 16'(BUS_TIMEOUT - 1)) begin
                    state_d = TIMEOUT;
`endif
                end
            end
`ifdef ARBITER_WATCHDOG_EN
            TIMEOUT: state_d = RELEASE;
`endif
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 3'(NR_MASTERS - 1);
            owner_q   <= '0;
            granted_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            granted_q <= granted_d;
            valid_q   <= (state_d != IDLE);
        end
    end

`ifdef ARBITER_WATCHDOG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            eot_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            eot_q <= (state_d == TIMEOUT);
            err_q <= (state_d == TIMEOUT);
        end
    end

    assign end_transaction_out = eot_q;
    assign error_out           = err_q;
`else
    assign end_transaction_out = 1'b0;
    assign error_out           = 1'b0;
`endif

    assign granted     = granted_q;
    assign bus_owner   = owner_q;
    assign owner_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr.
module tb_bus_arbiter_rr;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] request = '0;
    logic       bti = 1'b0;
    logic       eti = 1'b0;
    logic       erri = 1'b0;
    logic [3:0] granted;
    logic [2:0] bus_owner;
    logic       owner_valid;
    logic       eto;
    logic       erro;

    int total = 0;
    int bad = 0;
    int n;
    logic seen;

    bus_arbiter_rr #(
        .NR_MASTERS(4),
        .GRANT_TIMEOUT(16),
        .BUS_TIMEOUT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .request(request),
        .begin_transaction_in(bti),
        .end_transaction_in(eti),
        .error_in(erri),
        .granted(granted),
        .bus_owner(bus_owner),
        .owner_valid(owner_valid),
        .end_transaction_out(eto),
        .error_out(erro)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input int idx,
                              output int cyc);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (granted == '0 && cyc < 60);
        chk({tag, "_gnt"}, 32'(granted), 32'(oh));
        chk({tag, "_own"}, 32'(bus_owner), idx);
        chk({tag, "_vld"}, 32'(owner_valid), 1);
    endtask

    // Called at the grant negedge; returns at the RELEASE negedge.
    task automatic do_txn(input string tag, input logic use_err);
        bti = 1'b1;
        @(negedge clock);
        bti  = 1'b0;
        eti  = ~use_err;
        erri = use_err;
        @(negedge clock);
        eti  = 1'b0;
        erri = 1'b0;
        chk({tag, "_relv"}, 32'(owner_valid), 1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_gnt", 32'(granted), 0);
        chk("rst_vld", 32'(owner_valid), 0);
        chk("rst_own", 32'(bus_owner), 0);
        chk("rst_eto", 32'({eto, erro}), 0);
        reset = 1'b1;
        @(negedge clock);

        // Fairness: all request, order 0,1,2,3,0, back-to-back spacing.
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("fair%0d", k), k % 4, n);
            chk($sformatf("fair%0d_lat", k), n, (k == 0) ? 1 : 2);
            if (k == 4) request = '0;
            do_txn($sformatf("fair%0d", k), k == 2);
        end
        @(negedge clock);
        chk("fair_idle_vld", 32'(owner_valid), 0);

        // Single requester with slow begin/end.
        request = 4'b0001;
        wait_grant("single", 0, n);
        chk("single_lat", n, 1);
        request = '0;
        @(negedge clock);
        chk("single_pulse", 32'(granted), 0);
        chk("single_hold", 32'(owner_valid), 1);
        bti = 1'b1;
        @(negedge clock);
        bti = 1'b0;
        repeat (6) @(negedge clock);
        chk("single_busy_vld", 32'(owner_valid), 1);
        eti = 1'b1;
        @(negedge clock);
        eti = 1'b0;
        chk("single_rel_vld", 32'(owner_valid), 1);
        @(negedge clock);
        chk("single_drop_vld", 32'(owner_valid), 0);

        // Rotation: 2 served, then 0101 must go to 0.
        request = 4'b0100;
        wait_grant("rot_a", 2, n);
        request = 4'b0101;
        do_txn("rot_a", 1'b0);
        wait_grant("rot_b", 0, n);
        chk("rot_b_lat", n, 2);
        request = '0;
        do_txn("rot_b", 1'b0);
        @(negedge clock);

        // Master 1 granted but never begins.
        request = 4'b1010;
        wait_grant("gto_a", 1, n);
        request = 4'b1000;
`ifdef ARBITER_WATCHDOG_EN
        seen = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (eto || erro) seen = 1'b1;
        end while (granted == '0 && n < 60);
        chk("gto_cyc", n, 18);
        chk("gto_noerr", 32'(seen), 0);
        chk("gto_next", 32'(granted), 32'(4'b1000));
        chk("gto_next_own", 32'(bus_owner), 3);
        request = '0;
        do_txn("gto_b", 1'b0);
`else
        repeat (40) @(negedge clock);
        chk("gwait_vld", 32'(owner_valid), 1);
        chk("gwait_own", 32'(bus_owner), 1);
        chk("gwait_gnt", 32'(granted), 0);
        request = '0;
        do_txn("gwait", 1'b0);
`endif
        @(negedge clock);

        // Transaction that never ends.
        request = 4'b0001;
        wait_grant("bto", 0, n);
        request = '0;
        bti = 1'b1;
`ifdef ARBITER_WATCHDOG_EN
        n = 0;
        do begin
            @(negedge clock);
            bti = 1'b0;
            n++;
        end while (!eto && n < 60);
        chk("bto_cyc", n, 9);
        chk("bto_eto", 32'(eto), 1);
        chk("bto_err", 32'(erro), 1);
        @(negedge clock);
        chk("bto_pulse", 32'({eto, erro}), 0);
        chk("bto_rel_vld", 32'(owner_valid), 1);
        @(negedge clock);
        chk("bto_idle_vld", 32'(owner_valid), 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            bti = 1'b0;
            if (eto || erro) seen = 1'b1;
        end
        chk("bwait_noto", 32'(seen), 0);
        chk("bwait_vld", 32'(owner_valid), 1);
        eti = 1'b1;
        @(negedge clock);
        eti = 1'b0;
        @(negedge clock);
        chk("bwait_done", 32'(owner_valid), 0);
`endif

        // Asynchronous reset in the middle of a transaction.
        request = 4'b0010;
        wait_grant("arst", 1, n);
        request = '0;
        bti = 1'b1;
        @(negedge clock);
        bti = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_vld", 32'(owner_valid), 0);
        chk("arst_own", 32'(bus_owner), 0);
        chk("arst_gnt", 32'(granted), 0);
        chk("arst_eto", 32'({eto, erro}), 0);
        @(negedge clock);
        reset = 1'b1;
        request = 4'b1000;
        wait_grant("post_rst", 3, n);
        chk("post_rst_lat", n, 1);
        request = '0;
        do_txn("post_rst", 1'b0);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
